// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    // Error code for a completed frame; odd parity means data plus parity bit has an odd number of ones.
    function automatic logic [1:0] frame_err(
        input logic [DATA_BITS-1:0] data,
        input logic                 parity,
        input logic                 stop,
        input logic                 check_parity
    );
        logic [1:0] err;
        err = 2'b00;
        if (check_parity && !(^{data, parity}))
            err = err | ERR_PARITY;
        if (!stop)
            err = err | ERR_STOP;
        return err;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 clock and data, glitch-filters the clock and
// produces a one-cycle strobe on each filtered falling edge.
`timescale 1ns/1ps
module ps2_clk_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_sync
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] clk_chain;
    logic [SYNC_STAGES-1:0] data_chain;
    logic                   clk_synced;
    logic                   clk_filt;
    logic [CNT_W-1:0]       run_cnt;

    assign clk_synced = clk_chain[SYNC_STAGES-1];
    assign data_sync  = data_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_chain  <= '1;
            data_chain <= '1;
        end else begin
            clk_chain  <= {clk_chain[SYNC_STAGES-2:0], ps2_clk};
            data_chain <= {data_chain[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // run_cnt counts consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the run, so short glitches never get through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            run_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_synced == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_synced;
                run_cnt  <= '0;
                fall     <= ~clk_synced;
            end else begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver with parity/stop checking, stall timeout
// and a first-word-fall-through byte FIFO carrying per-byte error codes.
`timescale 1ns/1ps
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FIFO_DEPTH     = 4,
    parameter int CHECK_PARITY   = 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CLK_MOUSE_IN,
    input  logic                         DATA_MOUSE_IN,
    input  logic                         READ_ENABLE,
    input  logic                         POP,
    output logic [7:0]                   BYTE_READ,
    output logic [1:0]                   BYTE_ERROR_CODE,
    output logic                         BYTE_VALID,
    output logic [$clog2(FIFO_DEPTH):0]  FIFO_COUNT,
    output logic                         OVERFLOW,
    output logic                         TIMEOUT
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BIT_W  = $clog2(DATA_BITS);

    logic fall;
    logic data_s;

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk       (CLK),
        .rst       (RESET),
        .ps2_clk   (CLK_MOUSE_IN),
        .ps2_data  (DATA_MOUSE_IN),
        .fall      (fall),
        .data_sync (data_s)
    );

    ps2_state_t           state;
    logic [BIT_W-1:0]     bit_cnt;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic                 push_req;
    logic [DATA_BITS-1:0] push_data;
    logic [1:0]           push_err;

    // Deframing control: advances only on filtered falling edges.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            push_req <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            TIMEOUT  <= 1'b0;
            if (!READ_ENABLE) begin
                state    <= IDLE;
                idle_cnt <= '0;
            end else if (fall) begin
                idle_cnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == BIT_W'(DATA_BITS - 1))
                            state <= PARITY;
                        else
                            bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                    PARITY: state <= STOP;
                    STOP: begin
                        state    <= IDLE;
                        push_req <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    state    <= IDLE;
                    idle_cnt <= '0;
                    TIMEOUT  <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Frame payload; qualified by the control path so it needs no reset.
    always_ff @(posedge CLK) begin
        if (fall && READ_ENABLE) begin
            unique case (state)
                DATA:   shreg[bit_cnt] <= data_s;
                PARITY: parity_bit     <= data_s;
                STOP: begin
                    push_data <= shreg;
                    push_err  <= frame_err(shreg, parity_bit, data_s, CHECK_PARITY != 0);
                end
                default: ;
            endcase
        end
    end

    logic [7:0]       mem_data [FIFO_DEPTH];
    logic [1:0]       mem_err  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       last_data;
    logic [1:0]       last_err;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = POP && (count != '0);
    assign do_push = push_req && (!full || do_pop);

    // FIFO bookkeeping; last_* keep the most recently popped head visible when empty.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            OVERFLOW  <= 1'b0;
            last_data <= '0;
            last_err  <= '0;
        end else begin
            OVERFLOW <= push_req && full && !do_pop;
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_data <= mem_data[rd_ptr];
                last_err  <= mem_err[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_data[wr_ptr] <= push_data;
            mem_err[wr_ptr]  <= push_err;
        end
    end

    assign BYTE_VALID      = (count != '0);
    assign BYTE_READ       = BYTE_VALID ? mem_data[rd_ptr] : last_data;
    assign BYTE_ERROR_CODE = BYTE_VALID ? mem_err[rd_ptr]  : last_err;
    assign FIFO_COUNT      = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: randomized PS/2 frames, a queue-based
// reference model, and a monitor that pops and compares FIFO heads.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

    localparam int SYNC  = 2;
    localparam int FLEN  = 8;
    localparam int TMO   = 600;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       READ_ENABLE;
    logic       POP;
    logic [7:0] byte_a, byte_b;
    logic [1:0] err_a, err_b;
    logic       valid_a, valid_b;
    logic [2:0] cnt_a, cnt_b;
    logic       ovf_a, ovf_b, tmo_a, tmo_b;

    ps2_rx_fifo #(
        .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1)
    ) u_dut (
        .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(CLK_MOUSE_IN), .DATA_MOUSE_IN(DATA_MOUSE_IN),
        .READ_ENABLE(READ_ENABLE), .POP(POP), .BYTE_READ(byte_a), .BYTE_ERROR_CODE(err_a),
        .BYTE_VALID(valid_a), .FIFO_COUNT(cnt_a), .OVERFLOW(ovf_a), .TIMEOUT(tmo_a)
    );

    ps2_rx_fifo #(
        .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH(DEPTH), .CHECK_PARITY(0)
    ) u_np (
        .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(CLK_MOUSE_IN), .DATA_MOUSE_IN(DATA_MOUSE_IN),
        .READ_ENABLE(READ_ENABLE), .POP(POP), .BYTE_READ(byte_b), .BYTE_ERROR_CODE(err_b),
        .BYTE_VALID(valid_b), .FIFO_COUNT(cnt_b), .OVERFLOW(ovf_b), .TIMEOUT(tmo_b)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic [1:0] e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   auto_pop = 1'b0;
    int   pop_at = -1;
    int   lat = 12;
    int   t_stop = 0, t_fall = 0, t_valid = 0, t_tmo = 0;
    int   ovf_seen = 0, ovf_seen_b = 0, tmo_seen = 0, tmo_seen_b = 0;
    int   exp_ovf = 0, exp_tmo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference model: what a completed frame must leave in the FIFO.
    task automatic model_push(input logic [7:0] d, input logic par, input logic stop, input bit with_pop);
        exp_t e;
        e.d    = d;
        e.e[1] = ~stop;
        e.e[0] = (($countones({d, par}) % 2) == 0);
        t_stop = cyc;
        if (exp_q.size() >= DEPTH && !with_pop)
            exp_ovf++;
        else
            exp_q.push_back(e);
        if (with_pop)
            pop_at = cyc + lat - 1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop,
                              input int nbits, input bit glitch, input bit with_pop);
        logic [10:0] bits;
        logic        par;
        int          lo, hi;
        par  = ~(^d) ^ par_flip;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            lo = $urandom_range(30, 20);
            hi = $urandom_range(30, 20);
            DATA_MOUSE_IN = bits[i];
            if (glitch) begin
                wait_cyc(hi / 2 - 4);
                CLK_MOUSE_IN = 1'b0;
                wait_cyc(3);
                CLK_MOUSE_IN = 1'b1;
                wait_cyc(hi - hi / 2 + 1);
            end else begin
                wait_cyc(hi);
            end
            if (i == 10)
                model_push(d, par, stop, with_pop);
            CLK_MOUSE_IN = 1'b0;
            t_fall = cyc;
            wait_cyc(lo);
            CLK_MOUSE_IN = 1'b1;
        end
        DATA_MOUSE_IN = 1'b1;
        wait_cyc(30);
    endtask

    task automatic manual_pop();
        pop_at = cyc;
        wait_cyc(2);
    endtask

    // Monitor: counts pulses and compares each popped head against the scoreboard.
    initial begin
        exp_t e;
        bit   prev_valid;
        prev_valid = 1'b0;
        POP = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            POP = 1'b0;
            if (ovf_a) ovf_seen++;
            if (ovf_b) ovf_seen_b++;
            if (tmo_a) begin
                tmo_seen++;
                t_tmo = cyc;
            end
            if (tmo_b) tmo_seen_b++;
            if (valid_a && !prev_valid) t_valid = cyc;
            prev_valid = valid_a;
            if (valid_a && (auto_pop || cyc == pop_at)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", byte_a);
                end else begin
                    e = exp_q.pop_front();
                    check("head_byte", byte_a, e.d);
                    check("head_err", err_a, e.e);
                    check("nopar_valid", valid_b, 1);
                    check("nopar_byte", byte_b, e.d);
                    check("nopar_err", err_b, e.e & 2'b10);
                end
                POP = 1'b1;
            end
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        RESET = 1'b1;
        CLK_MOUSE_IN = 1'b1;
        DATA_MOUSE_IN = 1'b1;
        READ_ENABLE = 1'b1;
        wait_cyc(3);
        check("rst_byte", byte_a, 0);
        check("rst_err", err_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_tmo", tmo_a, 0);
        RESET = 1'b0;
        wait_cyc(5);

        // Single clean frame, held until popped by hand.
        send_frame(8'hFA, 0, 1, 11, 0, 0);
        check("fa_valid", valid_a, 1);
        check("fa_count", cnt_a, 1);
        lat = t_valid - t_stop;
        check("fa_latency_range", (lat >= FLEN + 2 && lat <= FLEN + SYNC + 5), 1);
        manual_pop();
        check("fa_empty_valid", valid_a, 0);
        check("fa_empty_count", cnt_a, 0);
        check("fa_hold_byte", byte_a, 8'hFA);
        check("fa_hold_err", err_a, 2'b00);

        // Error codes, glitch rejection and randomized traffic.
        auto_pop = 1'b1;
        send_frame(8'hFA, 1, 1, 11, 0, 0);
        send_frame(8'h81, 0, 0, 11, 0, 0);
        send_frame(8'h5A, 0, 1, 11, 1, 0);
        for (int i = 0; i < 12; i++) begin
            d = $urandom_range(255);
            send_frame(8'(d), ($urandom_range(3) == 0), ($urandom_range(7) != 0),
                       11, 1'($urandom_range(1)), 0);
        end

        // Stalled frame: start bit plus three data bits.
        send_frame(8'h35, 0, 1, 4, 0, 0);
        exp_tmo++;
        wait_cyc(TMO + 60);
        check("tmo_pulses", tmo_seen, exp_tmo);
        check("tmo_delay_range", (t_tmo - t_fall >= TMO && t_tmo - t_fall <= TMO + FLEN + SYNC + 4), 1);
        check("tmo_no_push", cnt_a, 0);
        send_frame(8'h12, 0, 1, 11, 0, 0);

        // Fill past capacity, then push and pop in the same cycle while full.
        wait_cyc(5);
        auto_pop = 1'b0;
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 0, 1, 11, 0, 0);
        check("full_count", cnt_a, DEPTH);
        check("ovf_pulses", ovf_seen, exp_ovf);
        send_frame(8'h06, 0, 1, 11, 0, 1);
        check("full_pushpop_count", cnt_a, DEPTH);
        check("full_pushpop_no_ovf", ovf_seen, exp_ovf);
        for (int i = 0; i < DEPTH; i++)
            manual_pop();
        check("drained_count", cnt_a, 0);

        // READ_ENABLE dropped mid-frame must discard it without a timeout.
        auto_pop = 1'b1;
        send_frame(8'hC3, 0, 1, 5, 0, 0);
        READ_ENABLE = 1'b0;
        wait_cyc(3);
        READ_ENABLE = 1'b1;
        wait_cyc(TMO + 60);
        check("re_no_tmo", tmo_seen, exp_tmo);
        check("re_no_push", cnt_a, 0);
        send_frame(8'h3C, 0, 1, 11, 0, 0);

        // Asynchronous reset mid-frame with two bytes queued.
        auto_pop = 1'b0;
        send_frame(8'h11, 0, 1, 11, 0, 0);
        send_frame(8'h22, 0, 1, 11, 0, 0);
        check("pre_rst_count", cnt_a, 2);
        send_frame(8'h77, 0, 1, 6, 0, 0);
        @(negedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        check("arst_byte", byte_a, 0);
        check("arst_err", err_a, 0);
        check("arst_valid", valid_a, 0);
        check("arst_count", cnt_a, 0);
        check("arst_nopar_byte", byte_b, 0);
        check("arst_nopar_count", cnt_b, 0);
        exp_q.delete();
        wait_cyc(3);
        RESET = 1'b0;
        wait_cyc(10);
        auto_pop = 1'b1;
        send_frame(8'hAA, 0, 1, 11, 0, 0);
        check("post_rst_count", cnt_a, 0);

        wait_cyc(20);
        check("scoreboard_drained", exp_q.size(), 0);
        check("ovf_total", ovf_seen, exp_ovf);
        check("ovf_total_nopar", ovf_seen_b, exp_ovf);
        check("tmo_total", tmo_seen, exp_tmo);
        check("tmo_total_nopar", tmo_seen_b, exp_tmo);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
